sap_ctrl_seq: RTL and testbench

- SAP-1 controller-sequencer. It is the initiating end of the control interface that the ALU, registers, PC, MAR and RAM respond to.
- Runs the T-state ring counter and decodes the 4-bit opcode from the instruction register.
- Drives the control word, including `su` (ALU bus enable) and `eu` (0 = add, 1 = subtract).
- Inserts wait states so the ALU's registered result is valid before `su` puts it on `dbus`.

---
 rtl/sap_ctrl_seq.sv | 113 +++++++++++
 tb/tb_sap_ctrl_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sap_ctrl_seq.sv
// sap_ctrl_seq: SAP-1 controller-sequencer with ALU wait-state insertion ahead of su.
module sap_ctrl_seq #(
  parameter int ALU_LAT = 1,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic [OPW-1:0] ir_op,
  output logic           cp,
  output logic           ep,
  output logic           lm_n,
  output logic           ce_n,
  output logic           li_n,
  output logic           ei_n,
  output logic           la_n,
  output logic           ea,
  output logic           su,
  output logic           eu,
  output logic           lb_n,
  output logic           lo_n,
  output logic           hlt,
  output logic [2:0]     tstate
);
  typedef enum logic [2:0] {
    T1 = 3'd0, T2 = 3'd1, T3 = 3'd2, T4 = 3'd3,
    T5 = 3'd4, WAIT = 3'd5, T6 = 3'd6, HALT = 3'd7
  } state_t;
  localparam logic [OPW-1:0] OP_LDA = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'he);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'hf);
  localparam logic [1:0] LAST = 2'(ALU_LAT > 0 ? ALU_LAT - 1 : 0);
  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic is_alu, is_sub, is_mem;
  assign is_sub = ir_op == OP_SUB;
  assign is_alu = ir_op == OP_ADD || is_sub;
  assign is_mem = ir_op == OP_LDA || is_alu;
  assign tstate = state;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state <= T1;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = '0;
    case (state)
      T1: state_nx = T2;
      T2: state_nx = T3;
      T3: state_nx = T4;
      T4: state_nx = is_mem ? T5 : ir_op == OP_HLT ? HALT : T1;
      T5: state_nx = !is_alu ? T1 : ALU_LAT > 0 ? WAIT : T6;
      WAIT: begin
        state_nx = cnt == LAST ? T6 : WAIT;
        cnt_nx = cnt == LAST ? 2'd0 : cnt + 2'd1;
      end
      T6: state_nx = T1;
      default: state_nx = HALT;
    endcase
  end
  // Controls are gated by clr_n so they drop asynchronously, not at the next edge.
  always_comb begin
    cp = 1'b0;
    ep = 1'b0;
    lm_n = 1'b1;
    ce_n = 1'b1;
    li_n = 1'b1;
    ei_n = 1'b1;
    la_n = 1'b1;
    ea = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lb_n = 1'b1;
    lo_n = 1'b1;
    hlt = 1'b0;
    if (clr_n) begin
      eu = is_sub && (state == T4 || state == T5 || state == WAIT || state == T6);
      case (state)
        T1: begin
          ep = 1'b1;
          lm_n = 1'b0;
        end
        T2: cp = 1'b1;
        T3: begin
          ce_n = 1'b0;
          li_n = 1'b0;
        end
        T4: begin
          ei_n = !is_mem;
          lm_n = !is_mem;
          ea = ir_op == OP_OUT;
          lo_n = ir_op != OP_OUT;
        end
        T5: begin
          ce_n = 1'b0;
          la_n = is_alu;
          lb_n = !is_alu;
        end
        T6: begin
          su = 1'b1;
          la_n = 1'b0;
        end
        HALT: hlt = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sap_ctrl_seq.sv
// tb_sap_ctrl_seq: checks three sequencers (ALU_LAT 1, 0, 3) against a per-cycle instruction table model.
module tb_sap_ctrl_seq;
  logic clk = 1'b0;
  logic clr_r [3];
  logic [3:0] op_r [3];
  logic [15:0] obs [3];
  int total = 0;
  int passed = 0;
  localparam logic [15:0] RST_V = 16'h3e30;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt;
    logic [2:0] tstate;
    sap_ctrl_seq #(.ALU_LAT(g == 0 ? 1 : g == 1 ? 0 : 3), .OPW(4)) dut (
      .clk(clk), .clr_n(clr_r[g]), .ir_op(op_r[g]),
      .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .ei_n(ei_n),
      .la_n(la_n), .ea(ea), .su(su), .eu(eu), .lb_n(lb_n), .lo_n(lo_n),
      .hlt(hlt), .tstate(tstate)
    );
    assign obs[g] = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt, tstate};
  end
  function automatic int lat_of(int i);
    return i == 0 ? 1 : i == 1 ? 0 : 3;
  endfunction
  function automatic int len_of(logic [3:0] op, int lat);
    return op == 4'h0 ? 5 : (op == 4'h1 || op == 4'h2) ? 6 + lat : 4;
  endfunction
  // Expected control word for cycle k (0 = T1) of an instruction.
  function automatic logic [15:0] expv(logic [3:0] op, int k, int lat);
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hl;
    int ts;
    bit alu, mem;
    alu = op == 4'h1 || op == 4'h2;
    mem = alu || op == 4'h0;
    {cp, ep, ea, su, eu, hl} = '0;
    {lm, ce, li, ei, la, lb, lo} = '1;
    ts = 0;
    if (k == 0) begin
      ep = 1; lm = 0;
    end else if (k == 1) begin
      cp = 1; ts = 1;
    end else if (k == 2) begin
      ce = 0; li = 0; ts = 2;
    end else if (k == 3) begin
      ts = 3;
      if (mem) begin ei = 0; lm = 0; end
      if (op == 4'he) begin ea = 1; lo = 0; end
    end else if (op == 4'hf) begin
      ts = 7; hl = 1;
    end else if (k == 4) begin
      ts = 4; ce = 0;
      if (alu) lb = 0; else la = 0;
    end else if (k < 5 + lat) begin
      ts = 5;
    end else begin
      ts = 6; su = 1; la = 0;
    end
    if (op == 4'h2 && k >= 3) eu = 1;
    return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hl, 3'(ts)};
  endfunction
  task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask
  task automatic chk_bus(int i);
    int n;
    n = int'(obs[i][14]) + int'(!obs[i][12]) + int'(!obs[i][10]) + int'(obs[i][8]) + int'(obs[i][7]);
    total++;
    assert (n <= 1) passed++;
    else $error("FAIL bus_excl dut%0d observed=%0d drivers expected<=1", i, n);
  endtask
  task automatic run_part(int i, logic [3:0] op, int n);
    op_r[i] = op;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("dut%0d op%h k%0d", i, op, k), obs[i], expv(op, k, lat_of(i)));
      chk_bus(i);
      @(posedge clk); #1;
    end
  endtask
  task automatic run_instr(int i, logic [3:0] op);
    run_part(i, op, len_of(op, lat_of(i)));
  endtask
  task automatic run_rand(int i, int n);
    for (int j = 0; j < n; j++) run_instr(i, 4'($urandom_range(0, 14)));
  endtask
  task automatic do_reset(int i);
    clr_r[i] = 1'b0;
    #1 chk($sformatf("dut%0d async_rst", i), obs[i], RST_V);
    @(negedge clk);
    chk($sformatf("dut%0d rst_hold", i), obs[i], RST_V);
    @(posedge clk); #1;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      clr_r[i] = 1'b0;
      op_r[i] = 4'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("dut%0d reset", i), obs[i], RST_V);
    clr_r[0] = 1'b1;
    run_instr(0, 4'h0);
    run_instr(0, 4'h2);
    run_instr(0, 4'he);
    run_instr(0, 4'h6);
    run_rand(0, 40);
    run_instr(0, 4'he);
    run_part(0, 4'hf, 4);
    for (int j = 0; j < 20; j++) begin
      op_r[0] = 4'($urandom);
      @(negedge clk);
      chk($sformatf("dut0 halt%0d", j), obs[0], expv(4'hf, 4 + j, 1));
      @(posedge clk); #1;
    end
    do_reset(0);
    clr_r[1] = 1'b1;
    run_instr(1, 4'h1);
    run_instr(1, 4'h2);
    run_rand(1, 25);
    do_reset(1);
    clr_r[2] = 1'b1;
    run_instr(2, 4'h1);
    run_rand(2, 25);
    run_part(2, 4'h1, 5);
    #2 clr_r[2] = 1'b0;
    #1 chk("dut2 wait_async_rst", obs[2], RST_V);
    @(negedge clk);
    chk("dut2 wait_rst_hold", obs[2], RST_V);
    @(posedge clk); #1;
    clr_r[2] = 1'b1;
    run_instr(2, 4'h1);
    run_instr(2, 4'h0);
    run_instr(2, 4'h2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
